seq_detector: RTL
=================

// Module: seq_detector
// PURPOSE
// - Serial pattern detector that consumes the bit stream produced by the lab D flip-flop
//   stage (its Q output feeds din).
// - Tracks the longest matched prefix of PATTERN with a small FSM.
// - Pulses match for one cycle when the full pattern has been seen.
// - Keeps a saturating count of matches for display/debug.
// PARAMETERS
// - PATTERN  4'b1011  pattern to detect; MSB is received first
// - OVERLAP  1        1 = overlapping matches allowed; 0 = restart from S0 after a match
// - CNT_W    8        width of match_cnt
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous, active-low reset
// - din        in   1      serial data bit (Q of upstream D flip-flop)
// - din_en     in   1      din is consumed on the rising edge only when din_en=1
// - clr        in   1      synchronous clear of FSM and counter
// - match      out  1      registered one-cycle pulse: pattern completed
// - match_cnt  out  CNT_W  saturating number of matches since reset/clr
// - state      out  2      current FSM state (matched prefix length 0..3)
// INTERFACE
// - One clock: clk. Reset: rst_n, asynchronous, active-low.
// - All outputs are registered.
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous): state=S0, match=0, match_cnt=0.
//   All three are held while rst_n=0.
// - States S0..S3 = number of PATTERN bits matched so far (0..3).
// - Each edge with din_en=1: let k = state, and form the candidate = first k bits of
//   PATTERN followed by din.
//   - If the candidate equals all 4 bits of PATTERN, it is a full match:
//     - match <= 1;
//     - match_cnt <= match_cnt+1, saturating at 2^CNT_W-1;
//     - next state = OVERLAP ? (length of the longest proper prefix of PATTERN that is
//       also a suffix of PATTERN) : S0.
//     - For 1011 with OVERLAP=1: next state = S1.
//   - Otherwise, next state = the longest prefix of PATTERN that is a suffix of the
//     candidate (KMP fallback).
// - Transition table for default PATTERN=1011 (next state for din=0 / din=1):
//   - S0: S0 / S1
//   - S1: S2 / S1
//   - S2: S0 / S3
//   - S3: S2 / match
// - Edge with din_en=0: state and match_cnt hold; match <= 0.
// - match is high for exactly one cycle per match, even when din_en is held high.
// - Latency: match is high in the cycle after the edge that sampled the last pattern bit.
// - clr=1 at an edge takes priority over din_en: state=S0, match_cnt=0, match=0.
//   A match completing on that same edge is discarded.
// - rst_n deassertion mid-stream: detection restarts from S0. Bits sampled before reset
//   never contribute to a match.
// - Counter saturation: once at 2^CNT_W-1, further matches still pulse match but the
//   count stays.
// STRUCTURE
// - Shared header seq_det_defs.vh: state encodings S0=2'd0 .. S3=2'd3, PAT_LEN=4.
// - Next-state/fallback logic is a combinational function inside seq_detector,
//   derived from PATTERN at elaboration time.
// - One sub-module: sat_counter (parameter W; inputs clk, rst_n, clr, inc; output cnt),
//   used for match_cnt.
// TESTING
// - Reset then din=1,0,1,1 with din_en=1 -> match=1 only in the cycle after the 4th
//   edge; match_cnt=1; state=S1.
// - OVERLAP=1, stream 1011011 -> match pulses after bits 4 and 7; match_cnt=2.
// - OVERLAP=0, stream 1011011 -> a single pulse after bit 4; match_cnt=1.
// - Stream 1,0,1,1 with din_en=0 for 3 cycles between each bit -> state holds during
//   the gaps; exactly one match pulse; no pulse repeats while din_en=0.
// - CNT_W=2 with 5 back-to-back overlapping matches -> 5 match pulses; match_cnt
//   sticks at 3.
// - Reset/clear corner cases:
//   - rst_n pulsed low asynchronously mid-edge after 1,0,1, then send 1 -> no match;
//     state=S1.
//   - clr=1 on the edge of the final bit -> match=0, match_cnt=0, state=S0.

Source files
------------

// File: rtl/seq_detector_pkg.sv
// Shared definitions for the serial pattern detector: pattern length and
// FSM state encoding (state value = number of pattern bits matched so far).
package seq_detector_pkg;

    localparam int PAT_LEN = 4;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == {W{1'b1}}) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector: KMP-style FSM tracking the longest matched prefix
// of PATTERN, a registered one-cycle match pulse and a saturating match count.
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_en,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       state
);

    localparam logic [PAT_LEN:0] ONE  = {{PAT_LEN{1'b0}}, 1'b1};
    localparam logic [2:0]       FULL = 3'(PAT_LEN);

    // Longest prefix of PATTERN that is a suffix of (first k pattern bits, b).
    // Sequences are held MSB-first, so a length-j prefix is PATTERN >> (PAT_LEN-j).
    function automatic logic [2:0] kmp_next(input logic [1:0] k, input logic b);
        logic [PAT_LEN:0] pat_ext;
        logic [PAT_LEN:0] cand;
        logic [PAT_LEN:0] mask;
        logic [2:0]       best;
        pat_ext = {1'b0, PATTERN};
        cand    = ((pat_ext >> (PAT_LEN - int'(k))) << 1) | {{PAT_LEN{1'b0}}, b};
        best    = 3'd0;
        for (int j = 1; j <= PAT_LEN; j++) begin
            mask = (ONE << j) - ONE;
            if ((j <= int'(k) + 1) && ((cand & mask) == (pat_ext >> (PAT_LEN - j))))
                best = 3'(j);
        end
        return best;
    endfunction

    // Longest proper prefix of PATTERN that is also a suffix: resume point after a match.
    function automatic logic [1:0] border_len();
        logic [PAT_LEN:0] pat_ext;
        logic [PAT_LEN:0] mask;
        logic [1:0]       best;
        pat_ext = {1'b0, PATTERN};
        best    = 2'd0;
        for (int j = 1; j < PAT_LEN; j++) begin
            mask = (ONE << j) - ONE;
            if ((pat_ext & mask) == (pat_ext >> (PAT_LEN - j)))
                best = 2'(j);
        end
        return best;
    endfunction

    localparam state_t OVL_STATE = state_t'(border_len());

    state_t     state_p1;
    state_t     state_d;
    logic       match_p1;
    logic       match_d;
    logic       inc;
    logic [2:0] nxt_len;

    always_comb begin
        state_d = state_p1;
        match_d = 1'b0;
        inc     = 1'b0;
        nxt_len = kmp_next(state_p1, din);
        if (clr) begin
            state_d = S0;
        end else if (din_en) begin
            if (nxt_len == FULL) begin
                match_d = 1'b1;
                inc     = 1'b1;
                state_d = OVERLAP ? OVL_STATE : S0;
            end else begin
                state_d = state_t'(nxt_len[1:0]);
            end
        end
    end

    // ---- stage p1: registered state and match pulse ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= S0;
            match_p1 <= 1'b0;
        end else begin
            state_p1 <= state_d;
            match_p1 <= match_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .inc  (inc),
        .cnt  (match_cnt)
    );

    assign match = match_p1;
    assign state = state_p1;

endmodule
